// File: rtl/dram_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_access_ctrl_pkg;

    // Access controller state machine encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bus operation encoding as seen on data_wr
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Default watchdog limit in cycles (only meaningful with DRAM_TIMEOUT_EN)
    localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/dram_access_ctrl_watchdog.sv
// Phase watchdog: counts cycles spent waiting on one bus handshake and flags expiry.
// Latency: expire_o asserts combinationally in the cycle the count reaches TIMEOUT_CYC-1.
// Backpressure: none; the count clears on every completed handshake or when not running.
module dram_watchdog
    import dram_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A handshake in the limit cycle wins over expiry
    assign expire_o = run_i && !clr_i && (cnt_q == LIMIT);

    // Next count: restart on handshake, expiry or when no phase is outstanding
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || clr_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dram_access_ctrl.sv
// MEM-stage data access unit: turns load/store requests into SRAM-like req/addr_ok/data_ok transactions.
// Latency: 3 stall cycles per single access, 5 for a combined store+load (store first, then load).
// Backpressure: stall_dram holds the pipeline until the access completes; DRAM_TIMEOUT_EN adds a phase watchdog.
module dram_access_ctrl
    import dram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                mem_read_ce,
    input  logic                mem_write_ce,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_dram,
    output logic                mem_err,
    output logic                data_req,
    output logic                data_wr,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W/8-1:0] data_wstrb,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q;
    logic                op_q;
    logic                pend_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                req_q;
    logic                err_q;
    logic                timeout;

`ifdef DRAM_TIMEOUT_EN
    logic phase_done;
    logic phase_run;

    assign phase_run  = (state_q == REQ) || (state_q == WAIT);
    assign phase_done = ((state_q == REQ) && data_addr_ok) || ((state_q == WAIT) && data_data_ok);

    dram_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk),
        .resetn_i (resetn),
        .run_i    (phase_run),
        .clr_i    (phase_done),
        .expire_o (timeout)
    );
`else
    // Without the watchdog a phase waits for its handshake indefinitely
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout = 1'b0;
`endif

    // Stall covers the request cycle in IDLE and every cycle a bus phase is outstanding
    assign stall_dram = ((state_q == IDLE) && (mem_read_ce || mem_write_ce))
                      || (state_q == REQ) || (state_q == WAIT);

    assign mem_rdata  = rdata_q;
    assign mem_err    = err_q;
    assign data_req   = req_q;
    assign data_wr    = op_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    // Byte enables only mean something for writes
    assign data_wstrb = (op_q == OP_WR) ? wstrb_q : '0;

    // Access sequencer: latch the request, run one or two bus phases, then release the pipeline for a cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            pend_rd_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read_ce || mem_write_ce) begin
                        addr_q    <= mem_addr;
                        wdata_q   <= mem_wdata;
                        wstrb_q   <= mem_wstrb;
                        pend_rd_q <= mem_read_ce;
                        op_q      <= mem_write_ce ? OP_WR : OP_RD;
                        req_q     <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else if (timeout) begin
                        req_q     <= 1'b0;
                        pend_rd_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (op_q == OP_RD) begin
                            rdata_q <= '0;
                        end
                        state_q <= DONE;
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        if (op_q == OP_RD) begin
                            rdata_q <= data_rdata;
                            state_q <= DONE;
                        end else if (pend_rd_q) begin
                            // Second phase of a combined access: load from the same address
                            op_q      <= OP_RD;
                            pend_rd_q <= 1'b0;
                            req_q     <= 1'b1;
                            state_q   <= REQ;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (timeout) begin
                        pend_rd_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (op_q == OP_RD) begin
                            rdata_q <= '0;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The ce inputs still belong to the retiring instruction; never re-issue here
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Scoreboard bench for dram_access_ctrl: directed cases followed by randomized load/store traffic.
// Latency: expected stall length is derived per instruction from the responder delays.
// Backpressure: a bus responder applies per-phase addr_ok/data_ok delays chosen by the stimulus.
module tb_dram_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_read_ce, mem_write_ce;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        stall_dram, mem_err;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    always #5 clk = ~clk;

    dram_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_read_ce  (mem_read_ce),
        .mem_write_ce (mem_write_ce),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .stall_dram   (stall_dram),
        .mem_err      (mem_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } bus_exp_t;
    typedef struct { int stalls; logic [31:0] rdata; logic err; int nbus; int drop; } done_exp_t;
    typedef struct { int a; int d; logic [31:0] rdata; } resp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    resp_t     resp_q[$];

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_rdata = 32'h0;

    int    rs_state = 0;
    int    rs_cnt   = 0;
    resp_t rs_cur;

    int mon_stall_cnt = 0;
    int mon_bus_cnt   = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    // Reference model: one bus phase per requested operation (store before load), each phase
    // costing (addr delay + 1) + (data delay + 1) cycles on top of the single IDLE request cycle.
    function automatic void expect_access(input bit rd, input bit wr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] wstrb,
                                          input int a0, input int d0, input int a1, input int d1,
                                          input logic [31:0] rdata);
        done_exp_t de;
        bus_exp_t  be;
        resp_t     rp;
        int        ai, di;
        de.stalls = 1;
        de.nbus   = 0;
        if (wr) begin
            be.wr = 1'b1; be.addr = addr; be.wdata = wdata; be.wstrb = wstrb;
            bus_q.push_back(be);
            rp.a = a0; rp.d = d0; rp.rdata = 32'h0;
            resp_q.push_back(rp);
            de.stalls += a0 + d0 + 2;
            de.nbus++;
        end
        if (rd) begin
            ai = wr ? a1 : a0;
            di = wr ? d1 : d0;
            be.wr = 1'b0; be.addr = addr; be.wdata = wdata; be.wstrb = 4'h0;
            bus_q.push_back(be);
            rp.a = ai; rp.d = di; rp.rdata = rdata;
            resp_q.push_back(rp);
            de.stalls += ai + di + 2;
            de.nbus++;
            model_rdata = rdata;
        end
        de.rdata = model_rdata;
        de.err   = 1'b0;
        de.drop  = 0;
        done_q.push_back(de);
    endfunction

    task automatic do_reset();
        resetn       = 1'b0;
        mem_read_ce  = 1'b0;
        mem_write_ce = 1'b0;
        bus_q.delete();
        done_q.delete();
        resp_q.delete();
        rs_state     = 0;
        model_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Waits (bounded) for the DONE cycle, then moves on to the following negedge
    task automatic wait_done();
        int n;
        n = 0;
        #1;
        while (stall_dram && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (stall_dram) begin
            compared++;
            mismatched++;
            $display("FAIL stall_timeout: stall_dram still 1 after %0d cycles, expected 0", n);
            do_reset();
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic run_inst(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            input int a0, input int d0, input int a1, input int d1,
                            input logic [31:0] rdata);
        expect_access(rd, wr, addr, wdata, wstrb, a0, d0, a1, d1, rdata);
        mem_read_ce  = rd;
        mem_write_ce = wr;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_wstrb    = wstrb;
        wait_done();
    endtask

    task automatic idle(input int n);
        mem_read_ce  = 1'b0;
        mem_write_ce = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Bus responder: per phase, wait 'a' cycles before addr_ok, then 'd' cycles before data_ok
    initial begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom();
            if (rs_state == 0 && data_req === 1'b1 && resp_q.size() > 0) begin
                rs_cur   = resp_q.pop_front();
                rs_cnt   = rs_cur.a;
                rs_state = 1;
            end
            if (rs_state == 1) begin
                if (data_req !== 1'b1) begin
                    rs_state = 0;
                end else if (rs_cnt == 0) begin
                    data_addr_ok = 1'b1;
                    rs_cnt       = rs_cur.d;
                    rs_state     = 2;
                end else begin
                    rs_cnt--;
                end
            end else if (rs_state == 2) begin
                if (rs_cnt == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rs_cur.rdata;
                    rs_state     = 0;
                end else begin
                    rs_cnt--;
                end
            end
        end
    end

    // Monitor: checks bus requests against the expected phase list and retirements against the model
    initial begin
        bus_exp_t  be;
        done_exp_t de;
        forever begin
            @(negedge clk);
            #2;
            if (resetn !== 1'b1) begin
                mon_stall_cnt = 0;
                mon_bus_cnt   = 0;
            end else begin
                if (data_req === 1'b1) begin
                    if (bus_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL bus_unexpected: data_req=1 at addr 0x%0h, expected no request", data_addr);
                    end else begin
                        be = bus_q[0];
                        chk("bus_wr", 64'(data_wr), 64'(be.wr));
                        chk("bus_addr", 64'(data_addr), 64'(be.addr));
                        chk("bus_wstrb", 64'(data_wstrb), 64'(be.wstrb));
                        if (be.wr) chk("bus_wdata", 64'(data_wdata), 64'(be.wdata));
                        if (data_addr_ok) begin
                            void'(bus_q.pop_front());
                            mon_bus_cnt++;
                        end
                    end
                end
                if (mem_read_ce || mem_write_ce) begin
                    if (stall_dram === 1'b1) begin
                        mon_stall_cnt++;
                    end else begin
                        if (done_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL done_unexpected: stall_dram=%0b with no access outstanding", stall_dram);
                        end else begin
                            de = done_q.pop_front();
                            chk("stall_cycles", 64'(mon_stall_cnt), 64'(de.stalls));
                            chk("mem_rdata", 64'(mem_rdata), 64'(de.rdata));
                            chk("mem_err", 64'(mem_err), 64'(de.err));
                            chk("bus_count", 64'(mon_bus_cnt), 64'(de.nbus));
                            chk("done_req", 64'(data_req), 64'd0);
                            for (int k = 0; k < de.drop; k++) begin
                                if (bus_q.size() > 0) void'(bus_q.pop_front());
                            end
                        end
                        mon_stall_cnt = 0;
                        mon_bus_cnt   = 0;
                    end
                end else begin
                    chk("idle_stall", 64'(stall_dram), 64'd0);
                end
            end
        end
    end

    // Global bound on run time
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    // Stimulus
    initial begin
        resetn       = 1'b0;
        mem_read_ce  = 1'b0;
        mem_write_ce = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 64'(data_req), 64'd0);
        chk("rst_wr", 64'(data_wr), 64'd0);
        chk("rst_addr", 64'(data_addr), 64'd0);
        chk("rst_wdata", 64'(data_wdata), 64'd0);
        chk("rst_wstrb", 64'(data_wstrb), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        chk("rst_stall", 64'(stall_dram), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // Single load, immediate handshakes
        run_inst(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, 0, 0, 32'hDEAD_BEEF);
        // Store with addr_ok delayed two cycles; mem_rdata must keep the load result
        run_inst(1'b0, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'b0011, 2, 0, 0, 0, 32'h0);
        idle(1);
        // Combined store+load at one address
        run_inst(1'b1, 1'b1, 32'h8000_2000, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, 32'h0BAD_F00D);
        idle(1);
        // Two loads back to back, ce held across DONE
        run_inst(1'b1, 1'b0, 32'h8000_3000, 32'h0, 4'h0, 0, 0, 0, 0, 32'h1111_2222);
        run_inst(1'b1, 1'b0, 32'h8000_3004, 32'h0, 4'h0, 0, 0, 0, 0, 32'h3333_4444);
        idle(1);

        // Reset while waiting for data; the late data_ok must be ignored
        begin
            bus_exp_t be;
            resp_t    rp;
            be.wr = 1'b0; be.addr = 32'h8000_4000; be.wdata = 32'h0; be.wstrb = 4'h0;
            bus_q.push_back(be);
            rp.a = 0; rp.d = 1; rp.rdata = 32'hCAFE_F00D;
            resp_q.push_back(rp);
            mem_read_ce  = 1'b1;
            mem_write_ce = 1'b0;
            mem_addr     = 32'h8000_4000;
            mem_wdata    = 32'h0;
            @(negedge clk);
            @(negedge clk);
            resetn       = 1'b0;
            mem_read_ce  = 1'b0;
            done_q.delete();
            model_rdata  = 32'h0;
            @(negedge clk);
            resetn = 1'b1;
            #1;
            chk("wrst_req", 64'(data_req), 64'd0);
            chk("wrst_wr", 64'(data_wr), 64'd0);
            chk("wrst_addr", 64'(data_addr), 64'd0);
            chk("wrst_rdata", 64'(mem_rdata), 64'd0);
            chk("wrst_stall", 64'(stall_dram), 64'd0);
            @(negedge clk);
            #1;
            chk("late_ok_rdata", 64'(mem_rdata), 64'd0);
            chk("late_ok_req", 64'(data_req), 64'd0);
            chk("late_ok_stall", 64'(stall_dram), 64'd0);
            @(negedge clk);
        end

`ifdef DRAM_TIMEOUT_EN
        // Load whose addr_ok never comes: watchdog aborts after TO request cycles
        begin
            bus_exp_t  be;
            resp_t     rp;
            done_exp_t de;
            be.wr = 1'b0; be.addr = 32'h8000_5000; be.wdata = 32'h0; be.wstrb = 4'h0;
            bus_q.push_back(be);
            rp.a = 1000; rp.d = 0; rp.rdata = 32'h0;
            resp_q.push_back(rp);
            model_rdata = 32'h0;
            de.stalls = 1 + TO; de.rdata = 32'h0; de.err = 1'b1; de.nbus = 0; de.drop = 1;
            done_q.push_back(de);
            mem_read_ce  = 1'b1;
            mem_write_ce = 1'b0;
            mem_addr     = 32'h8000_5000;
            wait_done();
            idle(1);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            int          kind, gap;
            logic [31:0] addr, wd, rdv;
            logic [3:0]  ws;
            kind = int'($urandom_range(0, 2));
            addr = $urandom() & 32'hFFFF_FFFC;
            wd   = $urandom();
            rdv  = $urandom();
            ws   = 4'($urandom_range(1, 15));
            run_inst(kind != 1, kind != 0, addr, wd, ws,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rdv);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
        end

        idle(3);
        chk("leftover_bus", 64'(bus_q.size()), 64'd0);
        chk("leftover_done", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dram_access_ctrl.md
Name: dram_access_ctrl

Overview:
- Data-memory access unit in the MEM stage. Converts the stage's `mem_read_ce`/`mem_write_ce` requests into SRAM-like bus transactions (`req`/`addr_ok`/`data_ok`).
- Drives the `stall_dram` request that the pipeline stall unit consumes, holding PC, IF/ID, ID/EX and EX/MEMWB until each access completes.
- When read and write are requested together, it serialises them (write first, then read) instead of leaving the conflict to the stall unit.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-strobe width is DATA_W/8)
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with DRAM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous reset, active-low
- mem_read_ce  in  1  load requested by the instruction in MEM
- mem_write_ce  in  1  store requested by the instruction in MEM
- mem_addr  in  ADDR_W  access address
- mem_wdata  in  DATA_W  store data
- mem_wstrb  in  DATA_W/8  store byte enables
- mem_rdata  out  DATA_W  load result, registered
- stall_dram  out  1  stall request to the stall unit
- mem_err  out  1  one-cycle pulse on a timeout abort; tied 0 without the macro
- data_req  out  1  bus request
- data_wr  out  1  1 = write, 0 = read
- data_addr  out  ADDR_W  bus address
- data_wdata  out  DATA_W  bus write data
- data_wstrb  out  DATA_W/8  bus byte enables
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; all registered outputs 0, including mem_rdata, data_req and mem_err.
  - Reset mid-transaction abandons the transaction. A data_data_ok arriving afterwards in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- stall_dram is combinational:
  - 1 when (IDLE && (mem_read_ce||mem_write_ce)), or state is REQ or WAIT.
  - 0 in DONE.
- IDLE:
  - If either ce is set, latch addr, wdata, wstrb and pend_rd=mem_read_ce.
  - op = write if mem_write_ce, else read.
  - Go to REQ.
- REQ:
  - data_req=1. data_wr/addr/wdata/wstrb come from the latched registers. For reads, data_wstrb=0.
  - Outputs are held stable until data_addr_ok. On data_addr_ok, go to WAIT.
- WAIT:
  - data_req=0. data_data_ok in the same cycle as data_addr_ok is not legal and is ignored.
  - On data_data_ok with op=read: mem_rdata <= data_rdata, then go to DONE.
  - On data_data_ok with op=write and pend_rd=1: op <= read, then go to REQ (second phase, same address).
  - On data_data_ok with op=write and pend_rd=0: go to DONE.
- DONE:
  - Pipeline advances this cycle. The ce inputs still belong to the same instruction and are not re-issued.
  - Next state is IDLE unconditionally.
- Latency (minimum):
  - Single access: 3 stall cycles (IDLE, REQ, WAIT), pipeline advances in cycle 4.
  - Write+read: 5 stall cycles.
- mem_rdata holds its value until the next read completes. It is not cleared by writes.
- Back-to-back accesses are separated by exactly one non-stalled DONE cycle.

Optional Feature:
- Macro: DRAM_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in REQ/WAIT and clears on every phase completion.
  - When the count reaches TIMEOUT_CYC-1 without the awaited handshake:
    - go to DONE, drop data_req, skip any pending second phase;
    - mem_rdata <= 0 if op=read;
    - mem_err=1 for that one DONE cycle.
- Without the macro: no counter; mem_err is constant 0; waits are unbounded.

Decomposition:
- Shared package:
  - state enum (IDLE/REQ/WAIT/DONE);
  - bus op constants OP_RD=0, OP_WR=1;
  - default TIMEOUT_CYC.
- One natural sub-module, dram_watchdog: counter plus expiry compare, instantiated only under DRAM_TIMEOUT_EN. All other logic stays in the top module.

Test Plan:
1. Load at 0x80000010, data_addr_ok in the first REQ cycle, data_data_ok one cycle later with 0xDEADBEEF.
   -> stall_dram=1 for exactly 3 cycles; data_wr=0; mem_rdata=0xDEADBEEF in DONE; stall_dram=0 in DONE.
2. Store 0x12345678, wstrb 4'b0011, addr 0x80001000; data_addr_ok delayed 2 cycles.
   -> data_req held 3 cycles with stable data_wr=1/addr/wdata/wstrb; stall_dram=1 for 5 cycles; mem_rdata unchanged.
3. mem_read_ce=mem_write_ce=1, addr 0x80002000.
   -> two bus transactions (data_wr=1, then data_wr=0) at the same address; stall_dram=1 for 5 cycles; mem_rdata = second data_rdata.
4. Two consecutive loads, ce held across the DONE cycle.
   -> exactly 2 requests; one stall_dram=0 cycle between them; no duplicate request in DONE.
5. resetn=0 in WAIT, data_data_ok the next cycle.
   -> all outputs 0 after the reset edge; the late data_data_ok is ignored; mem_rdata stays 0.
6. (DRAM_TIMEOUT_EN, TIMEOUT_CYC=8) load with data_addr_ok never asserted.
   -> after 8 REQ cycles go to DONE; mem_err=1 for one cycle; mem_rdata=0; stall_dram drops.
